controlador_display_n_digitos: RTL

CONTROLADOR_DISPLAY_N_DIGITOS -- requirements
Module: controlador_display_n_digitos

---
 rtl/pkg_display.sv | 36 +++
 rtl/decodificador_hex_7segmentos.sv | 14 +
 rtl/controlador_display_n_digitos.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pkg_display.sv
// Shared constants and types for the multiplexed seven-segment display controller.
package pkg_display;

   // Segment pattern for a dark digit, {g,f,e,d,c,b,a} active low
   localparam logic [6:0] SEG_APAGADO = 7'h7F;

   // All anodes off; sliced down to the digit count by the user
   localparam logic [7:0] ANODO_APAGADO = 8'hFF;

   // Hex glyphs, {g,f,e,d,c,b,a} active low, indexed by nibble value
   localparam logic [15:0][6:0] TABLA_SEGMENTOS = {
      7'b0001110,  // F
      7'b0000110,  // E
      7'b0100001,  // d
      7'b1000110,  // C
      7'b0000011,  // b
      7'b0001000,  // A
      7'b0010000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

   // Per-digit drive presented to the output registers
   typedef struct packed {
      logic [6:0] segmentos;
      logic       punto;
   } salida_digito_t;

endpackage

// File: rtl/decodificador_hex_7segmentos.sv
// Combinational hex nibble to active-low seven-segment pattern.
module decodificador_hex_7segmentos
   import pkg_display::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segmentos_c
);

   // Table lookup of the glyph for the selected nibble
   always_comb begin
      segmentos_c = TABLA_SEGMENTOS[nibble];
   end

endmodule

// File: rtl/controlador_display_n_digitos.sv
// N-digit multiplexed seven-segment controller with PWM brightness,
// leading-zero suppression and shadowed display data.
module controlador_display_n_digitos
   import pkg_display::*;
#(
   parameter int unsigned N_DIGITOS       = 4,
   parameter int unsigned CICLOS_REFRESCO = 100000
)(
   input  logic                   i_Reloj,
   input  logic                   i_Reset,
   input  logic [4*N_DIGITOS-1:0] i_Datos,
   input  logic [N_DIGITOS-1:0]   i_Puntos,
   input  logic                   i_Actualizar,
   input  logic [N_DIGITOS-1:0]   i_Habilitar_Digitos,
   input  logic                   i_Supresion_Ceros,
   input  logic [3:0]             i_Brillo,
   output logic [6:0]             o_Segmentos,
   output logic                   o_Punto,
   output logic [N_DIGITOS-1:0]   o_Anodo,
   output logic [2:0]             o_Digito_Activo,
   output logic                   o_Fin_Barrido
);

   localparam int unsigned ANCHO_DATOS = 4 * N_DIGITOS;
   localparam int unsigned CICLOS_FASE = CICLOS_REFRESCO / 16;
   localparam int unsigned ANCHO_PRE   = (CICLOS_FASE > 1) ? $clog2(CICLOS_FASE) : 1;
   localparam int unsigned ANCHO_IDX   = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
   localparam logic [ANCHO_PRE-1:0] PRE_ULTIMO = ANCHO_PRE'(CICLOS_FASE - 1);
   localparam logic [ANCHO_IDX-1:0] IDX_ULTIMO = ANCHO_IDX'(N_DIGITOS - 1);

   logic [ANCHO_PRE-1:0]   prescaler_q;
   logic [3:0]             fase_q;
   logic [ANCHO_IDX-1:0]   indice_q;
   logic                   fin_q;
   logic [ANCHO_DATOS-1:0] sombra_datos_q;
   logic [N_DIGITOS-1:0]   sombra_puntos_q;

   logic                   fin_prescaler_c;
   logic [3:0]             nibble_c;
   logic                   punto_sel_c;
   logic                   habil_sel_c;
   logic                   blanco_c;
   logic                   encendido_c;
   logic [6:0]             seg_dec_c;
   logic [N_DIGITOS-1:0]   anodo_c;
   salida_digito_t         salida_c;

   assign fin_prescaler_c = (prescaler_q == PRE_ULTIMO);

   // Prescaler, PWM phase and digit index; fin_q marks the first cycle after an index wrap
   always_ff @(posedge i_Reloj or posedge i_Reset) begin
      if (i_Reset) begin
         prescaler_q <= '0;
         fase_q      <= '0;
         indice_q    <= '0;
         fin_q       <= 1'b0;
      end else begin
         fin_q <= 1'b0;
         if (fin_prescaler_c) begin
            prescaler_q <= '0;
            fase_q      <= fase_q + 4'd1;
            if (fase_q == 4'hF) begin
               if (indice_q == IDX_ULTIMO) begin
                  indice_q <= '0;
                  fin_q    <= 1'b1;
               end else begin
                  indice_q <= indice_q + ANCHO_IDX'(1);
               end
            end
         end else begin
            prescaler_q <= prescaler_q + ANCHO_PRE'(1);
         end
      end
   end

   // Shadow copy of display data, loaded only on the update strobe
   always_ff @(posedge i_Reloj or posedge i_Reset) begin
      if (i_Reset) begin
         sombra_datos_q  <= '0;
         sombra_puntos_q <= '0;
      end else if (i_Actualizar) begin
         sombra_datos_q  <= i_Datos;
         sombra_puntos_q <= i_Puntos;
      end
   end

   // Select the active digit's nibble, point and enable; blank it if it and all higher nibbles are zero
   always_comb begin
      logic todo_cero;
      todo_cero   = 1'b1;
      nibble_c    = 4'h0;
      punto_sel_c = 1'b0;
      habil_sel_c = 1'b0;
      blanco_c    = 1'b0;
      for (int k = N_DIGITOS - 1; k >= 0; k--) begin
         todo_cero = todo_cero && (sombra_datos_q[4*k +: 4] == 4'h0);
         if (ANCHO_IDX'(k) == indice_q) begin
            nibble_c    = sombra_datos_q[4*k +: 4];
            punto_sel_c = sombra_puntos_q[k];
            habil_sel_c = i_Habilitar_Digitos[k];
            blanco_c    = i_Supresion_Ceros && (k != 0) && todo_cero;
         end
      end
   end

   decodificador_hex_7segmentos u_decodificador (
      .nibble      (nibble_c),
      .segmentos_c (seg_dec_c)
   );

   assign encendido_c = habil_sel_c && (fase_q <= i_Brillo);

   // Anode pattern and segment drive; a dark anode also darkens segments and point
   always_comb begin
      anodo_c = ANODO_APAGADO[N_DIGITOS-1:0];
      for (int k = 0; k < N_DIGITOS; k++) begin
         if ((ANCHO_IDX'(k) == indice_q) && encendido_c) begin
            anodo_c[k] = 1'b0;
         end
      end
      salida_c.segmentos = SEG_APAGADO;
      salida_c.punto     = 1'b1;
      if (encendido_c) begin
         salida_c.segmentos = blanco_c ? SEG_APAGADO : seg_dec_c;
         salida_c.punto     = ~punto_sel_c;
      end
   end

   // Output registers, forced dark while in reset
   always_ff @(posedge i_Reloj or posedge i_Reset) begin
      if (i_Reset) begin
         o_Anodo         <= ANODO_APAGADO[N_DIGITOS-1:0];
         o_Segmentos     <= SEG_APAGADO;
         o_Punto         <= 1'b1;
         o_Digito_Activo <= 3'd0;
         o_Fin_Barrido   <= 1'b0;
      end else begin
         o_Anodo         <= anodo_c;
         o_Segmentos     <= salida_c.segmentos;
         o_Punto         <= salida_c.punto;
         o_Digito_Activo <= 3'(indice_q);
         o_Fin_Barrido   <= fin_q;
      end
   end

endmodule
